// File: rtl/pipe_skid_wb_pkg.sv
// Shared definitions for the write-back skid stage.
// Provides the occupancy state encoding and the default widths used by
// pipe_skid_wb (data 32 bits, register address 5 bits, stall vector 5 bits).
package pipe_skid_wb_pkg;

    // Encoding doubles as the occupancy count presented on the port.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_STALL_W = 5;

endpackage

// File: rtl/pipe_skid_wb.sv
// Write-back stage with a two-entry skid buffer.
// Holds a main entry (drives the register-file write port) and a skid
// entry so that in_ready can be registered without losing data when the
// downstream side stops consuming.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is registered)
//   rd_data_i/rd_addr_i/rd_enable_i   upstream write-back payload
//   out_valid / out_ready    downstream handshake (out_valid is registered)
//   rd_data_o/rd_addr_o/rd_enable_o   write-back payload to register file
//   stall_signal             pipeline stall vector, only STALL_BIT is used
//   flush                    synchronous discard of all held entries
//   occupancy                number of held entries (0..2)
module pipe_skid_wb
    import pipe_skid_wb_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int STALL_W       = DEF_STALL_W,
    parameter int STALL_BIT     = 4,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  rd_data_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    input  logic               rd_enable_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    output logic               rd_enable_o,
    input  logic [STALL_W-1:0] stall_signal,
    input  logic               flush,
    output logic [1:0]         occupancy
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [DATA_W-1:0]   r_main_data;
    logic [ADDR_W-1:0]   r_main_addr;
    logic                r_main_en;
    logic [DATA_W-1:0]   r_skid_data;
    logic [ADDR_W-1:0]   r_skid_addr;
    logic                r_skid_en;

    logic                w_stall;
    logic                w_accept;
    logic                w_consume;
    logic                w_cap_en;
    logic                w_load_main_in;
    logic                w_load_skid_in;
    logic                w_move_skid;
    logic                w_unused_stall;

    assign w_stall        = stall_signal[STALL_BIT];
    // Remaining stall bits belong to other stages.
    assign w_unused_stall = ^stall_signal;

    assign w_accept  = in_valid && r_in_ready;
    // A stall blocks the hand-off, so entries are retained while stalled.
    assign w_consume = r_out_valid && out_ready && !w_stall;

    // Writes to register 0 are turned into no-ops at capture time.
    assign w_cap_en = rd_enable_i && !(ZERO_SUPPRESS && (rd_addr_i == '0));

    // State register. Handshake flags are derived from the next state so
    // that in_ready never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != FULL);
            r_out_valid <= (w_next_state != EMPTY);
        end
    end

    // Next-state logic; flush overrides every other condition.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) w_next_state = ONE;
                ONE: begin
                    if (w_accept && !w_consume)
                        w_next_state = FULL;
                    else if (!w_accept && w_consume)
                        w_next_state = EMPTY;
                end
                FULL:  if (w_consume) w_next_state = ONE;
                default: w_next_state = EMPTY;
            endcase
        end
    end

    // Output logic: entry load strobes and the masked write-back port.
    always_comb begin
        w_load_main_in = 1'b0;
        w_load_skid_in = 1'b0;
        w_move_skid    = 1'b0;
        if (!flush) begin
            case (r_state)
                EMPTY: w_load_main_in = w_accept;
                ONE: begin
                    w_load_main_in = w_accept && w_consume;
                    w_load_skid_in = w_accept && !w_consume;
                end
                FULL:  w_move_skid = w_consume;
                default: ;
            endcase
        end

        // The main entry may still hold stale payload after draining, so
        // everything is gated by out_valid.
        rd_data_o   = r_out_valid ? r_main_data : '0;
        rd_addr_o   = r_out_valid ? r_main_addr : '0;
        rd_enable_o = r_main_en && r_out_valid && !w_stall;
    end

    // Main and skid payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_data <= '0;
            r_main_addr <= '0;
            r_main_en   <= 1'b0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_en   <= 1'b0;
        end else if (flush) begin
            r_main_data <= '0;
            r_main_addr <= '0;
            r_main_en   <= 1'b0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_en   <= 1'b0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= rd_data_i;
                r_main_addr <= rd_addr_i;
                r_main_en   <= w_cap_en;
            end else if (w_move_skid) begin
                r_main_data <= r_skid_data;
                r_main_addr <= r_skid_addr;
                r_main_en   <= r_skid_en;
            end
            if (w_load_skid_in) begin
                r_skid_data <= rd_data_i;
                r_skid_addr <= rd_addr_i;
                r_skid_en   <= w_cap_en;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_skid_wb.sv
// Testbench for pipe_skid_wb: directed scenarios followed by random traffic,
// all checked against a queue-based reference of the two-entry buffer.
module tb_pipe_skid_wb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = 5;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] rd_data_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_enable_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] rd_data_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_enable_o;
    logic [SW-1:0] stall_signal;
    logic          flush;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    pipe_skid_wb dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rd_data_i    (rd_data_i),
        .rd_addr_i    (rd_addr_i),
        .rd_enable_i  (rd_enable_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rd_data_o    (rd_data_o),
        .rd_addr_o    (rd_addr_o),
        .rd_enable_o  (rd_enable_o),
        .stall_signal (stall_signal),
        .flush        (flush),
        .occupancy    (occupancy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          e;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at a clock edge: FIFO of at most two entries.
    task automatic model_edge();
        bit   acc;
        bit   con;
        ent_t e;
        if (rst) begin
            q.delete();
            m_ready = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            acc = in_valid && m_ready;
            con = (q.size() > 0) && out_ready && !stall_signal[SB];
            if (con) void'(q.pop_front());
            if (acc) begin
                e.d = rd_data_i;
                e.a = rd_addr_i;
                e.e = rd_enable_i && (rd_addr_i != 0);
                q.push_back(e);
            end
            m_ready = (q.size() != 2);
        end
    endtask

    task automatic check_all();
        ent_t f;
        bit   has;
        has = (q.size() > 0);
        f   = has ? q[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(has));
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("rd_data_o", 64'(rd_data_o), 64'(f.d));
        chk("rd_addr_o", 64'(rd_addr_o), 64'(f.a));
        chk("rd_enable_o", 64'(rd_enable_o), 64'(has && f.e && !stall_signal[SB]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input bit en, input bit ordy);
        in_valid    = v;
        rd_data_i   = d;
        rd_addr_i   = a;
        rd_enable_i = en;
        out_ready   = ordy;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        stall_signal = '0;
        flush = 1'b0;
        q.delete();
        m_ready = 1'b0;

        // Reset state
        #3;
        check_all();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Streaming 0x11, 0x22, 0x33 to addr 3
        drive(1'b1, 32'h11, 5'd3, 1'b1, 1'b1);
        cycle();
        chk("stream0", 64'(rd_data_o), 64'h11);
        drive(1'b1, 32'h22, 5'd3, 1'b1, 1'b1);
        cycle();
        chk("stream1", 64'(rd_data_o), 64'h22);
        chk("stream_occ", 64'(occupancy), 64'd1);
        drive(1'b1, 32'h33, 5'd3, 1'b1, 1'b1);
        cycle();
        chk("stream2", 64'(rd_data_o), 64'h33);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle();

        // Back-pressure
        drive(1'b1, 32'hA, 5'd7, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'hB, 5'd7, 1'b1, 1'b0);
        cycle();
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_ready", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(rd_data_o), 64'hA);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle();
        chk("bp_second", 64'(rd_data_o), 64'hB);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        cycle();

        // Stall on bit 4
        drive(1'b1, 32'hC, 5'd2, 1'b1, 1'b1);
        stall_signal = 5'b10000;
        cycle();
        chk("stall_en", 64'(rd_enable_o), 64'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle();
        chk("stall_keep", 64'(rd_data_o), 64'hC);
        stall_signal = 5'b00000;
        #1;
        check_all();
        chk("stall_release", 64'(rd_enable_o), 64'd1);
        cycle();

        // Zero suppress
        drive(1'b1, 32'hFF, 5'd0, 1'b1, 1'b0);
        cycle();
        chk("zs_valid", 64'(out_valid), 64'd1);
        chk("zs_en", 64'(rd_enable_o), 64'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle();

        // Flush while FULL with in_valid asserted
        drive(1'b1, 32'h5, 5'd9, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h6, 5'd9, 1'b1, 1'b0);
        cycle();
        flush = 1'b1;
        drive(1'b1, 32'h7, 5'd9, 1'b1, 1'b0);
        cycle();
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_data", 64'(rd_data_o), 64'd0);
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();

        // Asynchronous reset mid-cycle
        drive(1'b1, 32'h99, 5'd4, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_ready = 1'b0;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(rd_data_o), 64'd0);
        chk("arst_en", 64'(rd_enable_o), 64'd0);
        check_all();
        cycle();
        rst = 1'b0;
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, AW'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom_range(0, 2) != 0));
            stall_signal = SW'($urandom);
            if ($urandom_range(0, 2) != 0) stall_signal[SB] = 1'b0;
            flush = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_wb.md
PIPE_SKID_WB -- requirements
Module: pipe_skid_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the write-back data.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning width of the destination register address.
REQ-003 SHALL have parameter STALL_W, default 5, meaning width of the stall vector.
REQ-004 SHALL have parameter STALL_BIT, default 4, meaning the stall vector bit that stalls this stage.
REQ-005 SHALL have parameter ZERO_SUPPRESS, default 1, meaning that a write to address 0 is dropped.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-009 SHALL have ports rd_data_i (input, DATA_W), rd_addr_i (input, ADDR_W) and rd_enable_i (input, 1): upstream payload.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-011 SHALL have ports rd_data_o (output, DATA_W), rd_addr_o (output, ADDR_W) and rd_enable_o (output, 1): registered payload to the register file.
REQ-012 SHALL have port stall_signal, input, STALL_W bits: pipeline stall vector.
REQ-013 SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-014 SHALL have port occupancy, output, 2 bits: number of held entries (0..2).

Function
REQ-015 SHALL hold a two-entry store: a main entry driving the outputs and a skid entry; occupancy follows the state encoding EMPTY=0, ONE=1, FULL=2.
REQ-016 SHALL define accept = in_valid && in_ready, and consume = out_valid && out_ready && !stall_signal[STALL_BIT].
REQ-017 SHALL register in_ready as (next state != FULL), so that in_ready has no combinational path from out_ready.
REQ-018 SHALL register out_valid as (state != EMPTY).
REQ-019 SHALL make an entry accepted at edge N visible on the outputs after edge N (one-cycle latency) whenever state before edge N is EMPTY, or state is ONE and consume occurs.
REQ-020 SHALL apply these transitions from EMPTY: accept -> ONE (input loaded to main); otherwise stay in EMPTY.
REQ-021 SHALL apply these transitions from ONE:
- accept && consume -> ONE, with main loaded from input;
- accept && !consume -> FULL, with input loaded to skid;
- !accept && consume -> EMPTY;
- otherwise stay in ONE.
REQ-022 SHALL apply these transitions from FULL: consume -> ONE, with skid moved to main; otherwise stay in FULL. Input is never accepted in FULL (in_ready=0).
REQ-023 SHALL, while stall_signal[STALL_BIT]=1, retain all entries, and SHALL force rd_enable_o=0 combinationally (a downstream bubble) while still accepting into free space.
REQ-024 SHALL drive rd_enable_o = main_en && out_valid && !stall_signal[STALL_BIT].
REQ-025 SHALL, when ZERO_SUPPRESS=1, store the enable bit as 0 on capture of any entry whose rd_addr_i==0; data and address are still stored.
REQ-026 SHALL, on flush=1 at an edge, go to EMPTY, clear main and skid payloads to 0, and ignore any accept in that cycle; flush has priority over stall, accept and consume.
REQ-027 SHALL, when out_valid=0, drive rd_data_o=0, rd_addr_o=0 and rd_enable_o=0.
REQ-028 SHALL ignore stall_signal bits other than STALL_BIT.

Reset
REQ-029 SHALL, on rst=1 asynchronously, set state=EMPTY, occupancy=0, out_valid=0, in_ready=0, rd_data_o=0, rd_addr_o=0, rd_enable_o=0, and clear both entries.
REQ-030 SHALL raise in_ready=1 at the first rising edge after rst deasserts; reset asserted mid-transfer discards all entries without any output pulse.

Structure
REQ-031 SHALL take the state enum (EMPTY/ONE/FULL) and the default widths (data 32, register address 5, stall 5) from the shared package.
REQ-032 SHALL be implemented as a single module with no sub-module; the main and skid entries are inline register sets.

Verification
REQ-033 Streaming: valid every cycle with out_ready=1, data 0x11,0x22,0x33 to addr 3 -> outputs 0x11,0x22,0x33 on consecutive cycles, each one cycle after its accept; occupancy=1 throughout.
REQ-034 Back-pressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0; then out_ready=1 -> 0xA then 0xB, and in_ready returns to 1 after the first consume.
REQ-035 Stall: stall_signal=5'b10000 with main=0xC -> rd_enable_o=0 while stalled and entry retained; release -> rd_enable_o=1 with data 0xC.
REQ-036 Zero suppress: rd_addr_i=0, rd_enable_i=1, data 0xFF -> out_valid=1, rd_enable_o=0.
REQ-037 Flush/reset: in FULL, assert flush together with in_valid -> next cycle occupancy=0 and outputs 0; assert rst asynchronously mid-cycle -> outputs 0 immediately.
